// File: rtl/lcd_ctrl.sv
// HD44780 character LCD controller: power-up init, then timed writes of core bytes.
// Define LCD_CMD_FIFO_EN to add a 4-entry command FIFO in front of the write FSM.
module lcd_ctrl #(
    parameter int T_POWERUP   = 750000,
    parameter int T_SETUP     = 2,
    parameter int T_EN_HIGH   = 12,
    parameter int T_HOLD      = 1,
    parameter int T_CMD_WAIT  = 2000,
    parameter int T_LONG_WAIT = 82000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic       cmd_rs,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic       lcd_on
);

    localparam int MAX_A = (T_POWERUP > T_LONG_WAIT) ? T_POWERUP : T_LONG_WAIT;
    localparam int MAX_B = (MAX_A > T_CMD_WAIT) ? MAX_A : T_CMD_WAIT;
    localparam int MAX_C = (MAX_B > T_EN_HIGH) ? MAX_B : T_EN_HIGH;
    localparam int MAX_D = (MAX_C > T_SETUP) ? MAX_C : T_SETUP;
    localparam int T_MAX = (MAX_D > T_HOLD) ? MAX_D : T_HOLD;
    localparam int CW    = $clog2(T_MAX) + 1;

    localparam logic [CW-1:0] POWERUP_LAST = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] SETUP_LAST   = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] EN_LAST      = CW'(T_EN_HIGH - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] CMD_LAST     = CW'(T_CMD_WAIT - 1);
    localparam logic [CW-1:0] LONG_LAST    = CW'(T_LONG_WAIT - 1);

    typedef enum logic [2:0] {
        PWRUP, INIT_LOAD, SETUP, EN_HI, HOLD, WAIT, IDLE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    init_idx;
    logic          in_init;
    logic [CW-1:0] wait_last;
    logic          take;
    logic          next_rs;
    logic [7:0]    next_data;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: init_rom = 8'h38;
            3'd4:                   init_rom = 8'h0C;
            3'd5:                   init_rom = 8'h01;
            default:                init_rom = 8'h06;
        endcase
    endfunction

    // Clear display and return home need the long execution time.
    always_comb begin
        wait_last = CMD_LAST;
        if (!lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02 || lcd_data == 8'h03))
            wait_last = LONG_LAST;
    end

    assign lcd_rw = 1'b0;

`ifdef LCD_CMD_FIFO_EN
    logic [8:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] fifo_cnt;
    logic       fifo_push;

    assign cmd_ready = (fifo_cnt != 3'd4) && init_done;
    assign fifo_push = cmd_valid && cmd_ready;
    assign take      = (state == IDLE) && (fifo_cnt != 3'd0);
    assign next_rs   = fifo_mem[rd_ptr][8];
    assign next_data = fifo_mem[rd_ptr][7:0];

    always_ff @(posedge clk) begin
        if (fifo_push)
            fifo_mem[wr_ptr] <= {cmd_rs, cmd_data};
    end

    // Pop uses the registered count, so a byte pushed into an empty FIFO waits one extra cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push)
                wr_ptr <= wr_ptr + 2'd1;
            if (take)
                rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + {2'b00, fifo_push} - {2'b00, take};
        end
    end
`else
    assign cmd_ready = (state == IDLE);
    assign take      = cmd_valid && cmd_ready;
    assign next_rs   = cmd_rs;
    assign next_data = cmd_data;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= PWRUP;
            cnt       <= '0;
            lcd_data  <= '0;
            lcd_rs    <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_on    <= 1'b0;
            init_done <= 1'b0;
            in_init   <= 1'b0;
            init_idx  <= '0;
        end else begin
            lcd_on <= 1'b1;
            case (state)
                PWRUP: begin
                    if (cnt == POWERUP_LAST) begin
                        state    <= INIT_LOAD;
                        cnt      <= '0;
                        init_idx <= '0;
                        in_init  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                INIT_LOAD: begin
                    lcd_data <= init_rom(init_idx);
                    lcd_rs   <= 1'b0;
                    cnt      <= '0;
                    state    <= SETUP;
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state  <= EN_HI;
                        lcd_en <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EN_HI: begin
                    if (cnt == EN_LAST) begin
                        state  <= HOLD;
                        lcd_en <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == wait_last) begin
                        cnt <= '0;
                        if (in_init && init_idx != 3'd6) begin
                            init_idx <= init_idx + 3'd1;
                            state    <= INIT_LOAD;
                        end else begin
                            if (in_init) begin
                                init_done <= 1'b1;
                                in_init   <= 1'b0;
                            end
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (take) begin
                        lcd_data <= next_data;
                        lcd_rs   <= next_rs;
                        cnt      <= '0;
                        state    <= SETUP;
                    end
                end
                default: begin
                    state <= PWRUP;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
